// File: rtl/drp_reconf_sequencer_pkg.sv
// Shared constants for the DRP reconfiguration sequencer: FSM encoding,
// table-entry field layout and default parameter values.
package drp_reconf_sequencer_pkg;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ASSERT_RST = 4'd1;
  localparam logic [3:0] S_READ       = 4'd2;
  localparam logic [3:0] S_WAIT_R     = 4'd3;
  localparam logic [3:0] S_MODIFY     = 4'd4;
  localparam logic [3:0] S_WRITE      = 4'd5;
  localparam logic [3:0] S_WAIT_W     = 4'd6;
  localparam logic [3:0] S_NEXT       = 4'd7;
  localparam logic [3:0] S_RELEASE    = 4'd8;
  localparam logic [3:0] S_WAIT_LOCK  = 4'd9;
  localparam logic [3:0] S_ERROR      = 4'd10;

  // Table entry layout: {addr[38:32], mask[31:16], data[15:0]}
  localparam int ADDR_LSB = 32;
  localparam int MASK_LSB = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 16;

  localparam int DEF_NUM_REGS     = 23;
  localparam int DEF_DRDY_TIMEOUT = 255;
  localparam int DEF_LOCK_TIMEOUT = 4095;

  // One counter width covers both the DRDY and the LOCKED waits.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/drp_reconf_sequencer_drp_access.sv
// One DRP access: DEN/DWE for the request cycle, then waits for DRDY
// (ignoring the first wait cycle) with a saturating timeout.
module drp_access
  import drp_reconf_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_DRDY_TIMEOUT,
  parameter int CW      = 8
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              go,
  input  logic              we,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              drdy,
  output logic              den,
  output logic              dwe,
  output logic              ack,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata
);

  logic          pend;
  logic          first;
  logic          we_q;
  logic [CW-1:0] cnt;

  assign den     = go;
  assign dwe     = go & we;
  // The slave idles with DRDY high, so the cycle right after DEN is stale.
  assign ack     = pend & ~first & drdy;
  assign timeout = pend & ~ack & (cnt >= CW'(TIMEOUT));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      pend  <= 1'b0;
      first <= 1'b0;
      we_q  <= 1'b0;
      cnt   <= '0;
      rdata <= '0;
    end else if (go) begin
      pend  <= 1'b1;
      first <= 1'b1;
      we_q  <= we;
      cnt   <= '0;
    end else if (pend) begin
      first <= 1'b0;
      if (ack && !we_q) rdata <= rd_word;
      if (ack || timeout) pend <= 1'b0;
      else if (cnt < CW'(TIMEOUT)) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/drp_reconf_sequencer.sv
// DRP master: holds the PLL in reset, read-modify-writes every table entry,
// then releases reset and waits for LOCKED.
module drp_reconf_sequencer
  import drp_reconf_sequencer_pkg::*;
#(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic              DCLK,
  input  logic              RST_N,
  input  logic              START,
  output logic [5:0]        TBL_IDX,
  input  logic [38:0]       TBL_ENTRY,
  output logic [ADDR_W-1:0] DADDR,
  output logic              DEN,
  output logic              DWE,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO,
  input  logic              DRDY,
  output logic              PLL_RST,
  input  logic              LOCKED,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int         CW       = cnt_width(DRDY_TIMEOUT, LOCK_TIMEOUT);
  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] daddr_q;
  logic [CW-1:0]     lock_cnt;
  logic              acc_ack;
  logic              acc_to;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_mask;
  logic [DATA_W-1:0] ent_data;

  assign ent_addr = TBL_ENTRY[ADDR_LSB +: ADDR_W];
  assign ent_mask = TBL_ENTRY[MASK_LSB +: DATA_W];
  assign ent_data = TBL_ENTRY[0 +: DATA_W];

  assign BUSY  = (state != S_IDLE);
  // TBL_IDX only settles on entering READ, so the address comes straight from the table then.
  assign DADDR = (state == S_READ) ? ent_addr : daddr_q;

  drp_access #(.TIMEOUT(DRDY_TIMEOUT), .CW(CW)) u_acc (
    .gclk    (DCLK),
    .grst_n  (RST_N),
    .go      ((state == S_READ) || (state == S_WRITE)),
    .we      (state == S_WRITE),
    .rd_word (DO),
    .drdy    (DRDY),
    .den     (DEN),
    .dwe     (DWE),
    .ack     (acc_ack),
    .timeout (acc_to),
    .rdata   (rdata)
  );

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      TBL_IDX  <= '0;
      daddr_q  <= '0;
      DI       <= '0;
      PLL_RST  <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      lock_cnt <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: if (START) begin
          TBL_IDX <= '0;
          ERR     <= 1'b0;
          PLL_RST <= 1'b1;
          state   <= S_ASSERT_RST;
        end
        S_ASSERT_RST: state <= S_READ;
        S_READ: begin
          daddr_q <= ent_addr;
          state   <= S_WAIT_R;
        end
        S_WAIT_R:
          if (acc_ack)     state <= S_MODIFY;
          else if (acc_to) state <= S_ERROR;
        S_MODIFY: begin
          DI    <= (rdata & ent_mask) | ent_data;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_WAIT_W;
        S_WAIT_W:
          if (acc_ack)     state <= S_NEXT;
          else if (acc_to) state <= S_ERROR;
        S_NEXT:
          if (TBL_IDX == LAST_IDX) state <= S_RELEASE;
          else begin
            TBL_IDX <= TBL_IDX + 6'd1;
            state   <= S_READ;
          end
        S_RELEASE: begin
          PLL_RST  <= 1'b0;
          lock_cnt <= '0;
          state    <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK:
          if (LOCKED) begin
            DONE  <= 1'b1;
            state <= S_IDLE;
          end else if (lock_cnt >= CW'(LOCK_TIMEOUT)) state <= S_ERROR;
          else lock_cnt <= lock_cnt + CW'(1);
        S_ERROR: begin
          ERR     <= 1'b1;
          PLL_RST <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drp_reconf_sequencer.sv
// Directed + randomized bench: DRP register-file slave, PLL lock model and
// a read-modify-write reference model of the whole table walk.
module tb_drp_reconf_sequencer;

  localparam int NREG = 3;
  localparam int DTO  = 16;
  localparam int LTO  = 32;

  logic        DCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [5:0]  TBL_IDX;
  logic [38:0] TBL_ENTRY;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI, DO;
  logic        DRDY, PLL_RST, LOCKED, BUSY, DONE, ERR;

  always #5 DCLK = ~DCLK;

  drp_reconf_sequencer #(.NUM_REGS(NREG), .DRDY_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO)) dut (
    .DCLK(DCLK), .RST_N(RST_N), .START(START), .TBL_IDX(TBL_IDX), .TBL_ENTRY(TBL_ENTRY),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  logic [38:0] tbl [0:63];
  assign TBL_ENTRY = tbl[TBL_IDX];

  // DRP slave: DRDY high while idle, low after DEN, high again after a latency
  logic [15:0] regs [0:127];
  logic        s_drdy = 1'b1;
  logic        s_we = 1'b0;
  logic [6:0]  s_addr = 7'h0;
  logic [15:0] s_do = 16'h0;
  int          s_left = 0;
  bit          drdy_stuck = 0, rand_lat = 0, pl_en = 0;
  logic [6:0]  pl_addr = 7'h0;
  logic [15:0] pl_val = 16'h0;
  assign DRDY = s_drdy;
  assign DO   = s_do;

  always @(posedge DCLK) begin
    if (pl_en) regs[pl_addr] <= pl_val;
    if (DEN) begin
      s_drdy <= 1'b0;
      s_addr <= DADDR;
      s_we   <= DWE;
      s_left <= rand_lat ? int'($urandom_range(3, 1)) : 1;
      if (DWE) regs[DADDR] <= DI;
    end else if (s_left != 0) begin
      s_left <= s_left - 1;
      if (s_left == 1 && !drdy_stuck) begin
        s_drdy <= 1'b1;
        if (!s_we) s_do <= regs[s_addr];
      end
    end else if (!drdy_stuck) s_drdy <= 1'b1;
  end

  // PLL: locks lock_delay cycles after reset release (if lock_ok)
  bit   lock_high = 0, lock_ok = 1;
  int   lock_delay = 0, lk_cnt = 0;
  logic lk = 1'b0;
  always @(posedge DCLK) begin
    if (PLL_RST) begin
      lk_cnt <= 0;
      lk     <= 1'b0;
    end else if (lk_cnt < lock_delay) lk_cnt <= lk_cnt + 1;
    else lk <= lock_ok;
  end
  assign LOCKED = lock_high | lk;

  // Monitor: logs every DRP access as {we, addr, wdata-or-0}
  logic [23:0] mon_log [$];
  int  proto_err = 0, done_cnt = 0, busy_cyc = 0, unrst_acc = 0;
  bit  prev_den = 0, mon_clr = 0;
  always @(negedge DCLK) begin
    if (mon_clr) begin
      mon_log.delete();
      proto_err <= 0; done_cnt <= 0; busy_cyc <= 0; unrst_acc <= 0;
    end else begin
      if (DEN) mon_log.push_back({DWE, DADDR, DWE ? DI : 16'h0});
      if ((DEN && prev_den) || (DWE && !DEN)) proto_err <= proto_err + 1;
      if (DONE) done_cnt <= done_cnt + 1;
      if (BUSY) busy_cyc <= busy_cyc + 1;
      if (DEN && !PLL_RST) unrst_acc <= unrst_acc + 1;
    end
    prev_den <= DEN;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge DCLK);
    #2;
  endtask

  task automatic preload(input logic [6:0] a, input logic [15:0] v);
    pl_addr = a; pl_val = v; pl_en = 1; tick(); pl_en = 0;
  endtask

  // Reference: each entry in order does reg = (reg & mask) | data
  logic [15:0] mregs [0:127];
  logic [23:0] exp_log [$];
  task automatic build_exp(input bit full);
    logic [6:0]  a;
    logic [15:0] v;
    for (int i = 0; i < 128; i++) mregs[i] = regs[i];
    exp_log.delete();
    for (int i = 0; i < NREG; i++) begin
      a = tbl[i][38:32];
      v = (mregs[a] & tbl[i][31:16]) | tbl[i][15:0];
      exp_log.push_back({1'b0, a, 16'h0});
      if (!full) break;
      exp_log.push_back({1'b1, a, v});
      mregs[a] = v;
    end
  endtask

  task automatic check_run(input string tag);
    int bad = 0;
    chk({tag, ".nacc"}, mon_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < mon_log.size(); i++)
      chk($sformatf("%s.acc%0d", tag, i), mon_log[i], exp_log[i]);
    for (int a = 0; a < 128; a++) if (regs[a] !== mregs[a]) bad++;
    chk({tag, ".regs"}, bad, 0);
    chk({tag, ".proto"}, proto_err, 0);
    chk({tag, ".pll_during_acc"}, unrst_acc, 0);
  endtask

  task automatic run(input bit poke, input int bound, output bit timed_out, output logic err_after);
    bit poked = 0;
    mon_clr = 1; tick(); mon_clr = 0;
    START = 1; tick(); START = 0;
    err_after = ERR;
    timed_out = 1;
    for (int c = 0; c < bound; c++) begin
      if (!BUSY) begin timed_out = 0; break; end
      if (poke && !poked && DEN && DWE) begin
        tick(); START = 1; tick(); START = 0; poked = 1;
      end else tick();
    end
    tick();
  endtask

  task automatic rand_table();
    for (int i = 0; i < NREG; i++)
      tbl[i] = {7'($urandom_range(15, 0)), 16'($urandom), 16'($urandom)};
  endtask

  bit   to;
  logic ea;

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = 39'h0;
    tick();
    chk("rst.ctl", {BUSY, DEN, DWE, PLL_RST, DONE, ERR}, 0);
    chk("rst.data", {DADDR, DI, TBL_IDX}, 0);
    for (int a = 0; a < 128; a++) preload(7'(a), 16'($urandom));
    RST_N = 1;
    repeat (3) tick();
    chk("rst.idle_busy", BUSY, 0);

    // Directed: plain write, mask merge, partial mask; fixed latency, LOCKED high
    preload(7'h09, 16'h0043);
    tbl[0] = {7'h08, 16'h0000, 16'h6183};
    tbl[1] = {7'h09, 16'hFF00, 16'h0003};
    tbl[2] = {7'h0A, 16'h00FF, 16'h1200};
    rand_lat = 0; lock_high = 1;
    build_exp(1);
    run(0, 300, to, ea);
    chk("dir.timeout", to, 0);
    check_run("dir");
    chk("dir.r08", regs[8], 16'h6183);
    chk("dir.r09", regs[9], 16'h0003);
    chk("dir.done", done_cnt, 1);
    chk("dir.err", ERR, 0);
    chk("dir.idx", TBL_IDX, 2);
    chk("dir.pll", PLL_RST, 0);
    chk("dir.busy_cycles", busy_cyc, 1 + 8 * NREG + 2);
    lock_high = 0;

    // Async reset in the first WAIT_R cycle
    START = 1; tick(); START = 0;
    for (int c = 0; c < 20 && !DEN; c++) tick();
    tick();
    chk("rstmid.waiting", {BUSY, DEN, PLL_RST}, 3'b101);
    RST_N = 0; #1;
    chk("rstmid.async_ctl", {BUSY, DEN, DWE, PLL_RST, DONE, ERR}, 0);
    chk("rstmid.async_data", {DADDR, DI, TBL_IDX}, 0);
    tick();
    chk("rstmid.edge_ctl", {BUSY, DEN, PLL_RST}, 0);
    RST_N = 1;
    repeat (5) tick();
    chk("rstmid.stay_idle", BUSY, 0);

    // DRDY stuck low -> timeout after the first read, no write
    rand_table();
    drdy_stuck = 1; lock_ok = 1; lock_delay = 2;
    build_exp(0);
    run(0, 200, to, ea);
    chk("drdy.timeout_bound", to, 0);
    check_run("drdy");
    chk("drdy.err", ERR, 1);
    chk("drdy.pll", PLL_RST, 0);
    chk("drdy.done", done_cnt, 0);
    drdy_stuck = 0;
    repeat (3) tick();
    rand_table();
    build_exp(1);
    run(0, 300, to, ea);
    chk("recov.err_cleared", ea, 0);
    chk("recov.timeout", to, 0);
    check_run("recov");
    chk("recov.done", done_cnt, 1);
    chk("recov.err", ERR, 0);

    // LOCKED never arrives, plus a START pulse during WAIT_W
    rand_table();
    lock_ok = 0;
    build_exp(1);
    run(1, 300, to, ea);
    chk("lock.timeout_bound", to, 0);
    check_run("lock");
    chk("lock.err", ERR, 1);
    chk("lock.done", done_cnt, 0);
    chk("lock.idx", TBL_IDX, 2);
    chk("lock.pll", PLL_RST, 0);
    lock_ok = 1;

    // Randomized tables, slave latency and lock delay
    rand_lat = 1;
    for (int r = 0; r < 4; r++) begin
      rand_table();
      lock_delay = int'($urandom_range(8, 0));
      build_exp(1);
      run(0, 400, to, ea);
      chk($sformatf("rnd%0d.timeout", r), to, 0);
      check_run($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d.done", r), done_cnt, 1);
      chk($sformatf("rnd%0d.err", r), ERR, 0);
      chk($sformatf("rnd%0d.idx", r), TBL_IDX, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/drp_reconf_sequencer.md
Name: drp_reconf_sequencer

Overview:
Upstream DRP master for dyn_reconf; drives its DADDR/DEN/DWE/DI and consumes DO/DRDY.
On START it holds the PLL in reset and walks an external register table, doing a read-modify-write of each DRP register: new = (DO & MASK) | DATA.
It then releases PLL reset and waits for LOCKED before reporting DONE.
This lets a bench or top level retarget divide, duty and phase values without hand-sequencing DRP cycles.

Parameters:
NUM_REGS, 23, number of table entries processed per START (1..64)
DRDY_TIMEOUT, 255, DCLK cycles to wait for DRDY before flagging error
LOCK_TIMEOUT, 4095, DCLK cycles to wait for LOCKED after PLL reset release

Ports:
DCLK  in  1  DRP clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle request; sampled only in IDLE
TBL_IDX  out  6  table index currently addressed
TBL_ENTRY  in  39  {addr[38:32], mask[31:16], data[15:0]}; combinational from TBL_IDX
DADDR  out  7  DRP address
DEN  out  1  DRP enable
DWE  out  1  DRP write enable
DI  out  16  DRP write data
DO  in  16  DRP read data
DRDY  in  1  DRP ready
PLL_RST  out  1  reset to PLL model, high during reconfiguration
LOCKED  in  1  PLL lock
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse on successful completion
ERR  out  1  sticky timeout flag; cleared by next accepted START

Behaviour:
- Reset (async, RST_N=0): state IDLE. All outputs are 0: TBL_IDX, DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERR. Timeout counter and captured read word are 0.
- States: IDLE, ASSERT_RST, READ, WAIT_R, MODIFY, WRITE, WAIT_W, NEXT, RELEASE, WAIT_LOCK, ERROR.
- IDLE: if START=1, then TBL_IDX<=0, ERR<=0, PLL_RST<=1, go to ASSERT_RST. START in any other state is ignored.
- ASSERT_RST: one cycle; go to READ.
- READ: DEN=1, DWE=0, DADDR=TBL_ENTRY.addr, for exactly one cycle. Go to WAIT_R and clear the counter.
- WAIT_R:
  - DRDY is ignored on the first WAIT_R cycle, because the slave holds DRDY high when idle.
  - From the second cycle on, the first DRDY=1 captures DO, then go to MODIFY.
  - If the counter reaches DRDY_TIMEOUT, go to ERROR.
- MODIFY: DI<=(captured & mask)|data, registered. One cycle, then WRITE.
- WRITE: DEN=1, DWE=1, DADDR unchanged, DI held, for exactly one cycle. Go to WAIT_W.
- WAIT_W: same DRDY rule and timeout as WAIT_R; on DRDY go to NEXT.
- NEXT: if TBL_IDX==NUM_REGS-1, go to RELEASE. Otherwise TBL_IDX+1, go to READ. No wrap beyond NUM_REGS-1.
- RELEASE: PLL_RST<=0, clear counter, go to WAIT_LOCK.
- WAIT_LOCK:
  - LOCKED=1 gives DONE=1 for one cycle, then IDLE.
  - If the counter reaches LOCK_TIMEOUT, go to ERROR.
- ERROR: ERR<=1, PLL_RST<=0, DEN=DWE=0, go to IDLE. ERR stays set until the next START.
- DEN is never high on two consecutive cycles. DWE is high only together with DEN.
- DADDR and DI hold their last values between accesses.
- Counters saturate and do not wrap; width is clog2(max(DRDY_TIMEOUT, LOCK_TIMEOUT)+1).
- Asserting RST_N low mid-sequence aborts immediately to reset values. PLL_RST drops to 0 and partial writes are not rolled back.
- Latency per entry, with DRDY on the second wait cycle: 1+2+1+1+2+1 = 8 cycles.

Decomposition:
- Shared package: state encoding, table-entry field offsets (ADDR_LSB=32, MASK_LSB=16), default parameter constants.
- Natural sub-module: drp_access. It performs one DRP access per request (issue DEN/DWE, apply the DRDY rule, run the timeout, return rdata/ack/timeout). The sequencer instantiates it for both the read and the write phase.

Test Plan:
1. Reset: RST_N=0 mid-WAIT_R -> all outputs 0 on the next edge. After RST_N=1 and no START, BUSY stays 0.
2. Single RMW against dyn_reconf, NUM_REGS=1:
   - Entry {0x08, mask 0x0000, data 0x6183} -> one read then one write at 0x08 with DI=0x6183.
   - CLKOUT0_DIVIDE=9; PLL_RST high throughout.
   - LOCKED tied high -> DONE pulse.
3. Mask merge: preload reg 0x09 with 0x0043; entry {0x09, 0xFF00, 0x0003} -> DI=0x0003 (0x0043&0xFF00 = 0x0000, OR 0x0003).
4. Table walk, NUM_REGS=3 -> exactly 3 reads and 3 writes, with addresses in table order. TBL_IDX stops at 2. Sequence time is 3*8 cycles plus overhead.
5. DRDY timeout: slave DRDY forced 0 (DRDY_TIMEOUT=16) -> ERR=1, no DWE, PLL_RST=0, back in IDLE. The next START clears ERR.
6. Lock timeout and START-while-busy:
   - LOCKED=0 (LOCK_TIMEOUT=32) -> ERR=1, no DONE.
   - A START pulse during WAIT_W changes nothing.
